adc_capture_writer: RTL

//   Write side of the dual-channel sample buffers: the display path reads these buffers
//   by address 0..DEPTH-1, wrapping, on CS. On ARM, streams CH1/CH2 ADC samples into a

---
 rtl/adc_capture_writer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/adc_capture_writer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_writer
//  Description : Write side of the dual-channel circular sample buffers.
//                When armed, streams CH1/CH2 samples into the buffer, keeps
//                PRE pre-trigger samples, waits for a level/slope (or forced)
//                trigger, fills the rest of the frame and then freezes,
//                reporting the trigger and frame start addresses.
//  Ports       :
//    cs           sample clock, one sample per rising edge
//    rst          synchronous reset, active-high
//    arm          start a capture (level, ignored while busy)
//    force_trig   trigger immediately while waiting for a trigger
//    trig_src     0 = trigger on ch1_in, 1 = ch2_in
//    trig_slope   0 = rising, 1 = falling
//    trig_level   unsigned trigger threshold
//    ch1_in       channel 1 ADC sample
//    ch2_in       channel 2 ADC sample
//    wr_en        buffer write strobe
//    wr_addr      buffer write address (shared by both channels)
//    ch1_wr_data  channel 1 write data
//    ch2_wr_data  channel 2 write data
//    trig_addr    address holding the trigger sample
//    start_addr   oldest sample of the frame
//    busy         capture in progress
//    done         frame complete and frozen
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_writer #(
   parameter int DEPTH = 15360,
   parameter int AW    = 14,
   parameter int DW    = 12,
   parameter int PRE   = 7680
) (
   input  logic          cs,
   input  logic          rst,
   input  logic          arm,
   input  logic          force_trig,
   input  logic          trig_src,
   input  logic          trig_slope,
   input  logic [DW-1:0] trig_level,
   input  logic [DW-1:0] ch1_in,
   input  logic [DW-1:0] ch2_in,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] ch1_wr_data,
   output logic [DW-1:0] ch2_wr_data,
   output logic [AW-1:0] trig_addr,
   output logic [AW-1:0] start_addr,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] c_last_addr      = AW'(DEPTH - 1);
   localparam logic [AW-1:0] c_pre            = AW'(PRE);
   localparam logic [AW-1:0] c_pre_last       = AW'(PRE - 1);
   localparam logic [AW-1:0] c_depth_less_pre = AW'(DEPTH - PRE);
   localparam logic [AW-1:0] c_post_last      = AW'(DEPTH - PRE - 2);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PREFILL   = 3'd1,
      S_WAIT_TRIG = 3'd2,
      S_POST      = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [AW-1:0] r_ptr;
   logic [AW-1:0] r_cnt;
   logic          r_wr_en;
   logic [AW-1:0] r_wr_addr;
   logic [DW-1:0] r_ch1;
   logic [DW-1:0] r_ch2;
   logic [AW-1:0] r_trig_addr;
   logic [AW-1:0] r_start_addr;
   logic          r_busy;
   logic          r_done;

   logic [DW-1:0] w_cur;
   logic [DW-1:0] w_prev;
   logic          w_level_hit;
   logic          w_trig;
   logic [AW-1:0] w_ptr_next;
   logic [AW-1:0] w_start;
   logic          w_active;

   // The write-data registers always hold the last sample written since ARM,
   // so they double as the "previous sample" for slope detection.
   always_comb begin
      w_cur       = trig_src ? ch2_in : ch1_in;
      w_prev      = trig_src ? r_ch2  : r_ch1;
      w_level_hit = trig_slope ? ((w_prev > trig_level) && (w_cur <= trig_level))
                               : ((w_prev < trig_level) && (w_cur >= trig_level));
      w_trig      = (r_state == S_WAIT_TRIG) && (w_level_hit || force_trig);
      w_ptr_next  = (r_ptr == c_last_addr) ? '0 : r_ptr + 1'b1;
      // Modular subtraction without relying on 2**AW wrap.
      w_start     = (r_ptr >= c_pre) ? (r_ptr - c_pre) : (r_ptr + c_depth_less_pre);
      w_active    = (r_state == S_PREFILL) || (r_state == S_WAIT_TRIG) ||
                    (r_state == S_POST);
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (arm) w_state_next = S_PREFILL;
         end
         S_PREFILL: begin
            if (r_cnt == c_pre_last) w_state_next = S_WAIT_TRIG;
         end
         S_WAIT_TRIG: begin
            if (w_trig) w_state_next = S_POST;
         end
         S_POST: begin
            if (r_cnt == c_post_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            // First DONE edge retires busy; ARM is ignored until then.
            if (!r_busy && arm) w_state_next = S_PREFILL;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge cs) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Datapath and registered outputs
   always_ff @(posedge cs) begin
      if (rst) begin
         r_ptr        <= '0;
         r_cnt        <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_ch1        <= '0;
         r_ch2        <= '0;
         r_trig_addr  <= '0;
         r_start_addr <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else if (w_active) begin
         r_wr_en   <= 1'b1;
         r_wr_addr <= r_ptr;
         r_ch1     <= ch1_in;
         r_ch2     <= ch2_in;
         r_ptr     <= w_ptr_next;
         case (r_state)
            S_PREFILL: r_cnt <= (r_cnt == c_pre_last) ? '0 : r_cnt + 1'b1;
            S_WAIT_TRIG: begin
               if (w_trig) begin
                  r_trig_addr  <= r_ptr;
                  r_start_addr <= w_start;
                  r_cnt        <= '0;
               end
            end
            default: r_cnt <= r_cnt + 1'b1;
         endcase
      end else begin
         r_wr_en <= 1'b0;
         if ((r_state == S_DONE) && r_busy) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end else if (arm) begin
            r_done <= 1'b0;
            r_busy <= 1'b1;
            r_ptr  <= '0;
            r_cnt  <= '0;
         end
      end
   end

   assign wr_en       = r_wr_en;
   assign wr_addr     = r_wr_addr;
   assign ch1_wr_data = r_ch1;
   assign ch2_wr_data = r_ch2;
   assign trig_addr   = r_trig_addr;
   assign start_addr  = r_start_addr;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
`default_nettype wire
